multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
// - Parametrised N-bit adder/subtractor that evaluates CHUNK bits per clock through a registered carry.
// - Generalises the 4-bit ripple-carry adder: wider operands, a subtract mode, signed/zero flags and a
//   valid/ready handshake.
// - Sits between operand registers and a result consumer where a full-width ripple chain misses timing.
// PARAMETERS
// - WIDTH  16  operand/result width in bits; must be a multiple of CHUNK (elaboration $error otherwise)
// - CHUNK   4  bits added per cycle; NUM_CHUNKS = WIDTH/CHUNK, must be >= 1
// PORTS
// - i_clk        in   1      clock; all state updates on rising edge
// - i_reset      in   1      reset; synchronous, active-high
// - i_valid      in   1      operand set present
// - o_ready      out  1      block accepts operands (1 only in IDLE)
// - i_a          in   WIDTH  operand A
// - i_b          in   WIDTH  operand B
// - i_carry_in   in   1      carry-in (add) / borrow-in (sub)
// - i_sub        in   1      0: A+B+cin   1: A-B-bin, implemented as A + ~B + ~bin
// - o_valid      out  1      result valid; held until consumed
// - i_ready      in   1      consumer accepts result
// - o_s          out  WIDTH  sum/difference, mod 2^WIDTH
// - o_carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
// - o_overflow   out  1      signed overflow: MSB(A) == MSB(B_eff) and MSB(S) != MSB(A)
// - o_zero       out  1      o_s == 0
// BEHAVIOUR
// - Reset: state IDLE, chunk counter 0, carry register 0.
//   - o_s, o_carry_out, o_overflow, o_zero and o_valid are all 0; o_ready = 1 from the first cycle after reset.
//   - Reset has priority over every other event, including mid-CALC and DONE; the in-flight result is discarded.
// - States: IDLE -> CALC -> DONE -> IDLE.
// - IDLE:
//   - o_ready = 1.
//   - On edge with i_valid & o_ready: latch A, B_eff (B, or ~B if i_sub) and sub mode; carry reg = i_sub ? ~i_carry_in : i_carry_in.
//   - Counter = 0; go to CALC.
// - CALC:
//   - Each edge adds chunk[counter] of A and B_eff plus carry reg.
//   - Writes the CHUNK-bit sum into the o_s slice [counter*CHUNK +: CHUNK]; carry reg = chunk carry-out.
//   - Counter increments.
//   - On the edge processing chunk NUM_CHUNKS-1: o_carry_out, o_overflow and o_zero are set from the final values; o_valid = 1; go to DONE.
//   - Latency: o_valid rises NUM_CHUNKS edges after the accept edge.
// - DONE:
//   - o_valid = 1; all outputs stable.
//   - On edge with i_ready: o_valid = 0, go to IDLE; o_s and the flags keep their value.
//   - i_valid is ignored (o_ready = 0) for as long as i_ready stays low.
// - Throughput: one result per NUM_CHUNKS+2 cycles when i_valid and i_ready are held high.
// - Inputs are sampled only on the accept edge; changes to i_a, i_b, i_sub or i_carry_in during CALC/DONE have no effect.
// - o_s slices not yet written in CALC hold stale data; consumers read o_s only while o_valid = 1.
// - NUM_CHUNKS = 1 is legal: CALC lasts one cycle.
// STRUCTURE
// - Package adder_pkg:
//   - typedef enum logic [1:0] {IDLE, CALC, DONE} adder_state_t
//   - function num_chunks(width, chunk)
// - Sub-module ripple_carry_adder_n #(.N(CHUNK)):
//   - Combinational N-bit ripple adder built from full adders; ports i_a, i_b, i_carry_in, o_s, o_carry_out.
//   - Instantiated once and muxed by the chunk counter.
// - Counter width: $clog2(NUM_CHUNKS) with a minimum of 1.
// - All outputs except o_ready are registered; o_ready = (state == IDLE).
// TESTING (WIDTH=16, CHUNK=4; i_ready=1 unless stated)
// - 0x1234 + 0x4321, cin 0 -> o_s 0x5555, cout 0, ovf 0, zero 0; o_valid rises exactly 4 edges after accept.
// - 0xFFFF + 0x0001, cin 0 -> o_s 0x0000, cout 1, ovf 0, zero 1.
// - 0x7FFF + 0x0001, cin 0 -> o_s 0x8000, cout 0, ovf 1; 0x000F + 0x0000, cin 1 -> o_s 0x0010 (carry crosses a chunk boundary).
// - sub 0x0005 - 0x0007, bin 0 -> o_s 0xFFFE, cout 0, ovf 0; sub 0x8000 - 0x0001 -> o_s 0x7FFF, cout 1, ovf 1.
// - Backpressure: i_ready=0 for 3 cycles in DONE with i_valid=1 and new operands -> o_valid and o_s stay stable, o_ready=0, no new accept;
//   i_ready=1 -> IDLE, then the new operands are accepted.
// - i_reset pulsed during CALC (after 2 chunks) -> next cycle IDLE, o_valid 0, all outputs 0, o_ready 1; a following add of 1+1 gives 0x0002.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked multicycle adder.
// The FSM walks IDLE -> CALC -> DONE and returns to IDLE once the result is consumed.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (chunk > 0) ? width / chunk : 0;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_n.sv
// Combinational N-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
    output logic [N-1:0] o_s,
    output logic         o_carry_out
);

    logic [N:0] carry;

    assign carry[0] = i_carry_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_s[i]       = i_a[i] ^ i_b[i] ^ carry[i];
        assign carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry_out = carry[N];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder/subtractor that processes CHUNK bits per clock through a registered carry.
// Handshakes: a transfer happens on a rising edge where the sender's valid and the receiver's ready are both 1.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry_out,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    if (CHUNK < 1 || NUM_CHUNKS < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;

    // One shared chunk adder; the counter selects which slice of the operands it sees.
    assign chunk_a = a_q[cnt_q * CHUNK +: CHUNK];
    assign chunk_b = b_q[cnt_q * CHUNK +: CHUNK];

    ripple_carry_adder_n #(
        .N(CHUNK)
    ) u_chunk_adder (
        .i_a        (chunk_a),
        .i_b        (chunk_b),
        .i_carry_in (carry_q),
        .o_s        (chunk_s),
        .o_carry_out(chunk_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    // Subtraction is A + ~B + ~borrow, so invert both B and the incoming borrow.
                    a_d     = i_a;
                    b_d     = i_sub ? ~i_b : i_b;
                    carry_d = i_carry_in ^ i_sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d[cnt_q * CHUNK +: CHUNK] = chunk_s;
                carry_d = chunk_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cout_d  = chunk_c;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (s_d == '0);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = valid_q;
    assign o_s         = s_q;
    assign o_carry_out = cout_q;
    assign o_overflow  = ovf_q;
    assign o_zero      = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder (WIDTH=16, CHUNK=4) with hand-computed results.
module tb_multicycle_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic             i_clk;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry_in;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_carry_out;
    logic             o_overflow;
    logic             o_zero;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    multicycle_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_carry_in (i_carry_in),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_s        (o_s),
        .o_carry_out(o_carry_out),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    // Clock and reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: present one operand set in IDLE, hold it for the accept edge, then scramble inputs.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [WIDTH-1:0] exp_s);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_a        = a;
        i_b        = b;
        i_carry_in = cin;
        i_sub      = sub;
        i_valid    = 1'b1;
        exp_q.push_back(exp_s);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("ready_after_accept", 32'(o_ready), 32'd0);
        i_a        = WIDTH'($urandom);
        i_b        = WIDTH'($urandom);
        i_carry_in = 1'($urandom_range(0, 1));
        i_sub      = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for o_valid after the accept edge and compare against the scoreboard.
    task automatic await_result(input string tag, input logic cout, input logic ovf, input logic zero);
        int edges;
        logic [WIDTH-1:0] exp_s;
        edges = 0;
        while (!o_valid && edges < 20) begin
            @(posedge i_clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd4);
        if (exp_q.size() > 0) exp_s = exp_q.pop_front();
        else                  exp_s = 'x;
        check({tag, "_s"},    32'(o_s),         32'(exp_s));
        check({tag, "_cout"}, 32'(o_carry_out), 32'(cout));
        check({tag, "_ovf"},  32'(o_overflow),  32'(ovf));
        check({tag, "_zero"}, 32'(o_zero),      32'(zero));
    endtask

    // With i_ready high the result is consumed on the next edge; o_s must keep its value.
    task automatic consume(input string tag, input logic [WIDTH-1:0] held_s);
        @(posedge i_clk);
        #1;
        check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
        check({tag, "_s_held"},     32'(o_s),     32'(held_s));
    endtask

    initial begin
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_a        = '0;
        i_b        = '0;
        i_carry_in = 1'b0;
        i_sub      = 1'b0;
        i_ready    = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_ready", 32'(o_ready),     32'd1);
        check("reset_valid", 32'(o_valid),     32'd0);
        check("reset_s",     32'(o_s),         32'd0);
        check("reset_cout",  32'(o_carry_out), 32'd0);
        check("reset_ovf",   32'(o_overflow),  32'd0);
        check("reset_zero",  32'(o_zero),      32'd0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Additions
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555);
        await_result("add_5555", 1'b0, 1'b0, 1'b0);
        consume("add_5555", 16'h5555);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000);
        await_result("add_wrap", 1'b1, 1'b0, 1'b1);
        consume("add_wrap", 16'h0000);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000);
        await_result("add_ovf", 1'b0, 1'b1, 1'b0);
        consume("add_ovf", 16'h8000);

        send(16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010);
        await_result("add_cin_chunk", 1'b0, 1'b0, 1'b0);
        consume("add_cin_chunk", 16'h0010);

        // Subtractions: A - B - bin
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE);
        await_result("sub_neg", 1'b0, 1'b0, 1'b0);
        consume("sub_neg", 16'hFFFE);

        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF);
        await_result("sub_ovf", 1'b1, 1'b1, 1'b0);
        consume("sub_ovf", 16'h7FFF);

        send(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000);
        await_result("sub_zero", 1'b1, 1'b0, 1'b1);
        consume("sub_zero", 16'h0000);

        send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
        await_result("sub_bin", 1'b0, 1'b0, 1'b0);
        consume("sub_bin", 16'hFFFF);

        // Backpressure: result must hold in DONE while new operands wait
        i_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300);
        await_result("bp_first", 1'b0, 1'b0, 1'b0);
        i_a        = 16'h0011;
        i_b        = 16'h0022;
        i_carry_in = 1'b0;
        i_sub      = 1'b0;
        i_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            check("bp_valid_hold", 32'(o_valid), 32'd1);
            check("bp_s_hold",     32'(o_s),     32'h0300);
            check("bp_ready_low",  32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release_valid", 32'(o_valid), 32'd0);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        check("bp_release_s",     32'(o_s),     32'h0300);
        exp_q.push_back(16'h0033);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("bp_second_accept", 32'(o_ready), 32'd0);
        await_result("bp_second", 1'b0, 1'b0, 1'b0);
        consume("bp_second", 16'h0033);

        // Reset in the middle of CALC discards the in-flight result
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        exp_q.delete();
        check("midrst_ready", 32'(o_ready),     32'd1);
        check("midrst_valid", 32'(o_valid),     32'd0);
        check("midrst_s",     32'(o_s),         32'd0);
        check("midrst_cout",  32'(o_carry_out), 32'd0);
        check("midrst_ovf",   32'(o_overflow),  32'd0);
        check("midrst_zero",  32'(o_zero),      32'd0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002);
        await_result("after_rst", 1'b0, 1'b0, 1'b0);
        consume("after_rst", 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
